vote_session_ctrl: RTL and testbench
====================================

// Module: vote_session_ctrl
// PURPOSE
//  Sequences one ballot across N voters in front of the majority-vote datapath.
//  - Opens a voting window on start and accepts each voter's first yes/no only.
//  - Closes the window when all voters have voted or a timeout expires, then tallies once.
//  - Holds a strict-majority verdict until the next session.
// PARAMETERS
//  N_VOTERS      5     number of voters (odd, 3..15)
//  TIMEOUT_CYC   1000  max cycles the window stays open (>=2)
//  TMO_W         16    timer width; must satisfy TIMEOUT_CYC < 2**TMO_W
//  CNT_W         derived = $clog2(N_VOTERS+1); count width, not user-set
// PORTS
//  clk         in   1         system clock, rising edge
//  rst_n       in   1         asynchronous active-low reset
//  start       in   1         1-cycle pulse, opens a session; ignored unless IDLE or RESULT
//  vote_yes    in   N_VOTERS  per-voter yes strobe
//  vote_no     in   N_VOTERS  per-voter no strobe
//  voted       out  N_VOTERS  voter i has cast an accepted vote this session
//  yes_count   out  CNT_W     accepted yes votes this session
//  busy        out  1         high in OPEN and TALLY
//  done        out  1         1-cycle pulse on entry to RESULT
//  result      out  1         1 = yes_count > N_VOTERS/2; valid in RESULT
//  timed_out   out  1         session closed by timeout; valid in RESULT
// BEHAVIOUR
//  - Reset: all outputs 0, FSM in IDLE, timer 0, no_count 0; asynchronous assert, synchronous release.
//  - FSM states: IDLE, OPEN, TALLY, RESULT. All outputs are registered.
//  - IDLE/RESULT + start:
//    - clears voted, yes_count, no_count, timer, result, timed_out;
//    - next state OPEN; busy=1 from the cycle after start.
//  - OPEN, per voter i:
//    - accept only when voted[i]==0 and exactly one of vote_yes[i], vote_no[i] is high;
//    - on accept: voted[i]<=1 and yes_count or no_count increments;
//    - yes and no high in the same cycle: both ignored, voter stays unvoted;
//    - strobes after voted[i]==1 are ignored;
//    - strobes outside OPEN are ignored;
//    - several voters may be accepted in the same cycle; counts add the popcount.
//  - OPEN, timer and close:
//    - timer increments every OPEN cycle;
//    - leave OPEN when (voted incl. this cycle's accepts == all ones) OR timer == TIMEOUT_CYC-1;
//    - if both hold in the same cycle, completion wins and timed_out=0;
//    - votes accepted in the closing cycle are counted.
//  - TALLY (exactly 1 cycle):
//    - result <= (yes_count > N_VOTERS/2); unvoted voters count as no;
//    - timed_out <= 1 when closed by timeout with voters missing.
//  - RESULT:
//    - done=1 for the entry cycle only; busy=0;
//    - result, timed_out, voted, yes_count held until the next start.
//  - Latency:
//    - all N votes in one cycle k -> done at k+2;
//    - start at cycle 0 with no votes -> TALLY at TIMEOUT_CYC+1, done at TIMEOUT_CYC+2.
//  - start while OPEN/TALLY: ignored, no restart.
//  - Reset mid-session: immediate return to IDLE with reset values; no done pulse.
//  - Counters cannot overflow (max N_VOTERS fits CNT_W); the timer saturates by construction.
// CONFIGURATION
//  EARLY_DECIDE_EN defined:
//    - OPEN also closes once the verdict is fixed: yes_count >= N_VOTERS/2+1 or no_count >= N_VOTERS/2+1;
//    - this early close is not a timeout: timed_out=0;
//    - remaining voters' votes are not accepted after the early close.
//  EARLY_DECIDE_EN not defined:
//    - OPEN closes only on all-voted or timeout.
// TESTING
//  1 Reset then start; votes yes=5'b00111, no=5'b11000 in one cycle -> done 2 cycles later, yes_count=3, result=1, timed_out=0.
//  2 start; yes only from voters 0,1, then idle -> done at cycle TIMEOUT_CYC+2, timed_out=1, yes_count=2, result=0, voted=5'b00011.
//  3 Voter 2 pulses yes and no together, then yes twice -> only the 2nd strobe counted, yes_count=1, voted[2]=1.
//  4 start asserted while OPEN -> ignored, timer not cleared; rst_n low mid-OPEN -> all outputs 0, no done.
//  5 EARLY_DECIDE_EN: yes from voters 0,1,2 on separate cycles -> closes after 3rd, result=1, voted=5'b00111; without macro -> stays OPEN.
//  6 Second start from RESULT -> voted, yes_count, result cleared the next cycle; new session tallies independently.

Source files
------------

// File: rtl/vote_session_ctrl.sv
// Ballot sequencer for the majority-vote datapath: opens a window, latches first votes, tallies once.
// Optional EARLY_DECIDE_EN closes the window as soon as a strict majority is fixed.
module vote_session_ctrl #(
    parameter int  N_VOTERS    = 5,
    parameter int  TIMEOUT_CYC = 1000,
    parameter int  TMO_W       = 16,
    localparam int CNT_W       = $clog2(N_VOTERS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_VOTERS-1:0] vote_yes,
    input  logic [N_VOTERS-1:0] vote_no,
    output logic [N_VOTERS-1:0] voted,
    output logic [CNT_W-1:0]    yes_count,
    output logic                busy,
    output logic                done,
    output logic                result,
    output logic                timed_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPEN,
        S_TALLY,
        S_RESULT
    } state_t;

    localparam logic [CNT_W-1:0] HALF     = CNT_W'(N_VOTERS / 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
`ifdef EARLY_DECIDE_EN
    localparam logic [CNT_W-1:0] MAJ      = CNT_W'(N_VOTERS / 2 + 1);
`endif

    state_t              state_q;
    logic [N_VOTERS-1:0] voted_q, voted_d;
    logic [CNT_W-1:0]    yes_count_q, yes_count_d;
    logic [CNT_W-1:0]    no_count_q, no_count_d;
    logic [TMO_W-1:0]    timer_q;
    logic                tmo_close_q;
    logic                busy_q, done_q, result_q, timed_out_q;

    logic [N_VOTERS-1:0] accept;
    logic                all_voted, timer_hit, decided;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_VOTERS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_VOTERS; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latch).
    always_comb begin
        accept      = '0;
        voted_d     = voted_q;
        yes_count_d = yes_count_q;
        no_count_d  = no_count_q;
        all_voted   = 1'b0;
        timer_hit   = 1'b0;
        decided     = 1'b0;
        if (state_q == S_OPEN) begin
            // A voter counts only with exactly one strobe and no earlier vote this session.
            accept      = ~voted_q & (vote_yes ^ vote_no);
            voted_d     = voted_q | accept;
            yes_count_d = yes_count_q + popcount(accept & vote_yes);
            no_count_d  = no_count_q + popcount(accept & vote_no);
            all_voted   = &voted_d;
            timer_hit   = (timer_q == TMO_LAST);
`ifdef EARLY_DECIDE_EN
            decided     = (yes_count_d >= MAJ) || (no_count_d >= MAJ);
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            voted_q     <= '0;
            yes_count_q <= '0;
            no_count_q  <= '0;
            timer_q     <= '0;
            tmo_close_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RESULT: begin
                    if (start) begin
                        voted_q     <= '0;
                        yes_count_q <= '0;
                        no_count_q  <= '0;
                        timer_q     <= '0;
                        tmo_close_q <= 1'b0;
                        result_q    <= 1'b0;
                        timed_out_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_OPEN;
                    end
                end
                S_OPEN: begin
                    voted_q     <= voted_d;
                    yes_count_q <= yes_count_d;
                    no_count_q  <= no_count_d;
                    timer_q     <= timer_q + TMO_W'(1);
                    // Completion and early decision take priority over the timeout.
                    if (all_voted || decided || timer_hit) begin
                        tmo_close_q <= !(all_voted || decided);
                        state_q     <= S_TALLY;
                    end
                end
                S_TALLY: begin
                    result_q    <= (yes_count_q > HALF);
                    timed_out_q <= tmo_close_q;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    state_q     <= S_RESULT;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign voted     = voted_q;
    assign yes_count = yes_count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign timed_out = timed_out_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: per session, a reference model derives the close cycle
// and expected outputs from the stimulus schedule; directed cases plus randomized sessions.
module tb_vote_session_ctrl;

    localparam int N     = 5;
    localparam int T     = 20;
    localparam int CNT_W = $clog2(N + 1);
`ifdef EARLY_DECIDE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [N-1:0]     vote_yes = '0;
    logic [N-1:0]     vote_no = '0;
    logic [N-1:0]     voted;
    logic [CNT_W-1:0] yes_count;
    logic             busy, done, result, timed_out;

    logic [N-1:0] sy [0:T+2];
    logic [N-1:0] sn [0:T+2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vote_session_ctrl #(
        .N_VOTERS   (N),
        .TIMEOUT_CYC(T),
        .TMO_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .vote_yes (vote_yes),
        .vote_no  (vote_no),
        .voted    (voted),
        .yes_count(yes_count),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .timed_out(timed_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int c = 0; c <= T + 2; c++) begin
            sy[c] = '0;
            sn[c] = '0;
        end
    endtask

    // density = percent chance per voter per cycle of some strobe activity
    task automatic fill_random(input int density);
        for (int c = 0; c <= T + 2; c++) begin
            sy[c] = '0;
            sn[c] = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < density) begin
                    case ($urandom_range(0, 3))
                        0, 3: sy[c][i] = 1'b1;
                        1:    sn[c][i] = 1'b1;
                        default: begin
                            sy[c][i] = 1'b1;
                            sn[c][i] = 1'b1;
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " voted"}, 32'(voted), 32'd0);
        check({tag, " yes_count"}, 32'(yes_count), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " result"}, 32'(result), 32'd0);
        check({tag, " timed_out"}, 32'(timed_out), 32'd0);
    endtask

    task automatic run_session(input string name);
        logic [N-1:0] v;
        logic [N-1:0] ev [0:T+2];
        int           ey [0:T+2];
        int           ny, nn, close;
        bit           tmo, exp_res;

        // Reference: walk the OPEN window cycle by cycle with the voting rules.
        v = '0; ny = 0; nn = 0; close = T - 1; tmo = 1'b0;
        for (int c = 0; c < T; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && (sy[c][i] != sn[c][i])) begin
                    v[i] = 1'b1;
                    if (sy[c][i]) ny++;
                    else nn++;
                end
            end
            ev[c] = v;
            ey[c] = ny;
            if (v == '1 || (EARLY && (ny > N / 2 || nn > N / 2))) begin
                close = c;
                tmo   = 1'b0;
                break;
            end
            if (c == T - 1) tmo = 1'b1;
        end
        for (int c = close + 1; c <= close + 2; c++) begin
            ev[c] = v;
            ey[c] = ny;
        end
        exp_res = (ny > N / 2);

        @(negedge clk);
        start = 1'b1; vote_yes = '0; vote_no = '0;
        @(negedge clk);
        start = 1'b0;
        check({name, " open busy"}, 32'(busy), 32'd1);
        check({name, " open done"}, 32'(done), 32'd0);
        check({name, " open voted"}, 32'(voted), 32'd0);
        check({name, " open yes_count"}, 32'(yes_count), 32'd0);
        check({name, " open result"}, 32'(result), 32'd0);
        check({name, " open timed_out"}, 32'(timed_out), 32'd0);

        for (int j = 0; j <= close + 2; j++) begin
            vote_yes = sy[j];
            vote_no  = sn[j];
            // start during OPEN/TALLY must neither restart nor clear the timer
            start = (j <= close + 1) && (j == 3 || $urandom_range(0, 7) == 0);
            @(negedge clk);
            check($sformatf("%s busy j=%0d", name, j), 32'(busy), 32'(j <= close));
            check($sformatf("%s done j=%0d", name, j), 32'(done), 32'(j == close + 1));
            check($sformatf("%s voted j=%0d", name, j), 32'(voted), 32'(ev[j]));
            check($sformatf("%s yes_count j=%0d", name, j), 32'(yes_count), 32'(ey[j]));
            if (j > close) begin
                check($sformatf("%s result j=%0d", name, j), 32'(result), 32'(exp_res));
                check($sformatf("%s timed_out j=%0d", name, j), 32'(timed_out), 32'(tmo));
            end
        end
        start = 1'b0; vote_yes = '0; vote_no = '0;
    endtask

    task automatic mid_reset();
        fill_random(30);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            vote_yes = sy[j] & ~sn[j] & 5'b00001;
            vote_no  = '0;
            @(negedge clk);
        end
        vote_yes = '0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset async");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_all_zero($sformatf("mid_reset hold %0d", j));
        end
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_all_zero($sformatf("mid_reset idle %0d", j));
        end
    endtask

    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        clear_stim();
        sy[0] = 5'b00111; sn[0] = 5'b11000;
        run_session("t1_all_one_cycle");

        clear_stim();
        sy[0] = 5'b00011;
        run_session("t2_timeout");

        clear_stim();
        sy[0][2] = 1'b1; sn[0][2] = 1'b1;
        sy[1][2] = 1'b1;
        sy[2][2] = 1'b1;
        run_session("t3_both_then_yes");

        clear_stim();
        sy[0] = 5'b00001; sy[1] = 5'b00010; sy[2] = 5'b00100;
        run_session("t5_early");

        mid_reset();

        clear_stim();
        sn[1] = 5'b11111;
        run_session("t6_after_reset_all_no");

        for (int s = 0; s < 14; s++) begin
            fill_random(int'($urandom_range(5, 70)));
            run_session($sformatf("rand%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
